// File: rtl/nes_pad_responder.sv
// NES controller emulator: answers console latch/shift-clock with an active-low serial button stream.
// Optional turbo on A/B (bits 0 and 1) is enabled by defining NES_PAD_TURBO_EN.
module nes_pad_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int TURBO_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       latch_in,
    input  logic       pclk_in,
    input  logic [7:0] buttons,
    output logic       data_out,
    output logic       busy,
    output logic [3:0] bit_idx,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] pclk_sync;
    logic                   latch_hist;
    logic                   pclk_hist;
    logic                   latch_s;
    logic                   pclk_s;
    logic                   latch_rise;
    logic                   latch_fall;
    logic                   pclk_rise;

    logic [7:0] snapshot, snapshot_next;
    logic [7:0] captured;
    logic [3:0] bit_idx_next;
    logic [3:0] idx_inc;
    logic       data_next;
    logic       busy_next;
    logic [7:0] frame_next;

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign pclk_s     = pclk_sync[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_hist;
    assign latch_fall = ~latch_s & latch_hist;
    assign pclk_rise  = pclk_s & ~pclk_hist;
    assign idx_inc    = bit_idx + 4'd1;

    // History flops reset to 0 so a latch already high at reset release reads as a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_sync <= '0;
            pclk_sync  <= '0;
            latch_hist <= 1'b0;
            pclk_hist  <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
            pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], pclk_in};
            latch_hist <= latch_s;
            pclk_hist  <= pclk_s;
        end
    end

`ifdef NES_PAD_TURBO_EN
    localparam int TW = $clog2(TURBO_PERIOD + 1);

    logic [TW-1:0] turbo_cnt, turbo_cnt_next;
    logic          turbo_phase, turbo_phase_next;

    // The phase used for a frame is the one after this latch's update, so it is stable for the whole LOAD.
    always_comb begin
        turbo_cnt_next   = turbo_cnt;
        turbo_phase_next = turbo_phase;
        if (latch_rise) begin
            if (turbo_cnt == TW'(TURBO_PERIOD)) begin
                turbo_cnt_next   = TW'(1);
                turbo_phase_next = ~turbo_phase;
            end else begin
                turbo_cnt_next = turbo_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else begin
            turbo_cnt   <= turbo_cnt_next;
            turbo_phase <= turbo_phase_next;
        end
    end

    assign captured = {buttons[7:2], buttons[1:0] & {2{turbo_phase_next}}};
`else
    assign captured = buttons;
`endif

    always_comb begin
        state_next    = state;
        snapshot_next = snapshot;
        bit_idx_next  = bit_idx;
        data_next     = data_out;
        busy_next     = busy;
        frame_next    = frame_cnt;

        if (latch_rise) begin
            state_next    = LOAD;
            snapshot_next = captured;
            frame_next    = frame_cnt + 8'd1;
            bit_idx_next  = 4'd0;
            data_next     = ~captured[0];
            busy_next     = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    data_next    = 1'b1;
                    bit_idx_next = 4'd0;
                    busy_next    = 1'b0;
                end
                LOAD: begin
                    bit_idx_next = 4'd0;
                    busy_next    = 1'b1;
                    if (latch_fall) begin
                        state_next = SHIFT;
                        data_next  = ~snapshot[0];
                    end else begin
                        snapshot_next = captured;
                        data_next     = ~captured[0];
                    end
                end
                SHIFT: begin
                    busy_next = 1'b1;
                    if (pclk_rise) begin
                        if (bit_idx >= 4'd7) begin
                            state_next   = DONE;
                            bit_idx_next = 4'd8;
                            data_next    = 1'b1;
                            busy_next    = 1'b0;
                        end else begin
                            bit_idx_next = idx_inc;
                            data_next    = ~snapshot[idx_inc[2:0]];
                        end
                    end
                end
                DONE: begin
                    bit_idx_next = 4'd8;
                    data_next    = 1'b1;
                    busy_next    = 1'b0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snapshot  <= 8'd0;
            bit_idx   <= 4'd0;
            data_out  <= 1'b1;
            busy      <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_next;
            snapshot  <= snapshot_next;
            bit_idx   <= bit_idx_next;
            data_out  <= data_next;
            busy      <= busy_next;
            frame_cnt <= frame_next;
        end
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: a frame-level model predicts every output change,
// and a negedge monitor pops and compares each change the DUT presents.
module tb_nes_pad_responder;

    localparam int SS = 2;
    localparam int TP = 4;

    logic       clk;
    logic       rst;
    logic       latch_in;
    logic       pclk_in;
    logic [7:0] buttons;
    logic       data_out;
    logic       busy;
    logic [3:0] bit_idx;
    logic [7:0] frame_cnt;

    nes_pad_responder #(
        .SYNC_STAGES (SS),
        .TURBO_PERIOD(TP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .latch_in (latch_in),
        .pclk_in  (pclk_in),
        .buttons  (buttons),
        .data_out (data_out),
        .busy     (busy),
        .bit_idx  (bit_idx),
        .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic       d;
        logic [3:0] idx;
        logic       b;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        obs_t o;
        int   cyc;
        int   lim;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cycle  = 0;
    bit   mon_en = 0;

    // Frame-level model: frames since reset, frozen snapshot, position in the 8-bit report.
    int         m_frames;
    logic [7:0] m_snap;
    int         m_pos;
    bit         m_loaded;
    bit         m_latch;
    obs_t       m_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    endtask

    function automatic logic [7:0] capture(input logic [7:0] b, input int frame);
        logic [7:0] r;
        r = b;
`ifdef NES_PAD_TURBO_EN
        if (((frame - 1) / TP) % 2 == 0) r[1:0] = 2'b00;
`endif
        return r;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.b   = m_loaded && (m_pos < 8);
        o.d   = o.b ? ~m_snap[m_pos] : 1'b1;
        o.idx = 4'(m_pos);
        o.fc  = 8'(m_frames);
        return o;
    endfunction

    task automatic push_expected(input int lim);
        obs_t e;
        e = model_obs();
        if (e != m_last) begin
            sb.push_back('{o: e, cyc: cycle, lim: lim});
            m_last = e;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_rise();
        m_frames++;
        m_snap   = capture(buttons, m_frames);
        m_pos    = 0;
        m_loaded = 1;
    endtask

    task automatic latch_pulse(input logic [7:0] b);
        buttons  = b;
        latch_in = 1'b1;
        m_latch  = 1;
        model_rise();
        push_expected(SS + 2);
        wait_cycles(8);
        latch_in = 1'b0;
        m_latch  = 0;
        wait_cycles(8);
    endtask

    task automatic pclk_pulse();
        pclk_in = 1'b1;
        if (!m_latch && m_loaded && m_pos < 8) begin
            m_pos++;
            push_expected(SS + 2);
        end
        wait_cycles(8);
        pclk_in = 1'b0;
        wait_cycles(8);
    endtask

    task automatic set_buttons(input logic [7:0] b);
        buttons = b;
        wait_cycles(2);
    endtask

    // Reset must land on the very next clock edge; a latch held through reset reloads afterwards.
    task automatic reset_pulse();
        rst      = 1'b1;
        m_frames = 0;
        m_loaded = 0;
        m_pos    = 0;
        push_expected(1);
        wait_cycles(1);
        check_output("rst_next_data_out", data_out, 1);
        check_output("rst_next_bit_idx", bit_idx, 0);
        check_output("rst_next_busy", busy, 0);
        wait_cycles(1);
        rst = 1'b0;
        if (latch_in) begin
            m_latch = 1;
            model_rise();
            push_expected(SS + 2);
        end
        wait_cycles(8);
    endtask

    task automatic apply_stimulus();
        logic [7:0] seq;
        int         pressed;
        int         op;

        // Plain frame: 0x05 reads back as 0,1,0,1,1,1,1,1
        latch_pulse(8'h05);
        for (int i = 0; i < 8; i++) begin
            seq[i] = data_out;
            pclk_pulse();
        end
        check_output("frame_sequence", seq, 8'hFA);
        check_output("frame_done_data_out", data_out, 1);
        check_output("frame_done_busy", busy, 0);
        check_output("frame_done_frame_cnt", frame_cnt, 1);

        latch_pulse(8'h3A);
        set_buttons(8'hFF);
        repeat (8) pclk_pulse();

        latch_pulse(8'h96);
        repeat (3) pclk_pulse();
        latch_pulse(8'h69);
        repeat (2) pclk_pulse();

        latch_pulse(8'h10);
        repeat (4) pclk_pulse();
        reset_pulse();
        latch_pulse(8'hC3);
        repeat (12) pclk_pulse();

        latch_in = 1'b1;
        reset_pulse();
        latch_in = 1'b0;
        m_latch  = 0;
        wait_cycles(8);
        repeat (3) pclk_pulse();

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 11);
            if (op < 3) latch_pulse(8'($urandom));
            else if (op < 9) pclk_pulse();
            else if (op < 11) set_buttons(8'($urandom));
            else reset_pulse();
        end

        reset_pulse();
        pressed = 0;
        for (int f = 0; f < 16; f++) begin
            latch_pulse(8'h01);
            if (data_out == 1'b0) pressed++;
        end
`ifdef NES_PAD_TURBO_EN
        check_output("turbo_pressed_frames", pressed, 8);
`else
        check_output("turbo_pressed_frames", pressed, 16);
`endif
    endtask

    // Monitor: every change of the observable outputs must match the oldest prediction, in time.
    initial begin
        obs_t prev;
        obs_t cur;
        exp_t e;
        int   lat;
        wait (mon_en);
        @(negedge clk);
        prev = {data_out, bit_idx, busy, frame_cnt};
        forever begin
            @(negedge clk);
            cur = {data_out, bit_idx, busy, frame_cnt};
            if (cur !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL unexpected_change: actual %h required no change from %h", cur, prev);
                end else begin
                    e   = sb.pop_front();
                    lat = cycle - e.cyc;
                    if (cur === e.o && lat <= e.lim) passes++;
                    else $display("[TB] FAIL scoreboard: actual d=%b idx=%0d busy=%b fc=%0d after %0d cycles, required d=%b idx=%0d busy=%b fc=%0d within %0d cycles",
                                  cur.d, cur.idx, cur.b, cur.fc, lat, e.o.d, e.o.idx, e.o.b, e.o.fc, e.lim);
                end
                prev = cur;
            end
        end
    end

    initial begin
        int budget;
        rst      = 1'b1;
        latch_in = 1'b0;
        pclk_in  = 1'b0;
        buttons  = 8'h00;
        m_frames = 0;
        m_snap   = 8'h00;
        m_pos    = 0;
        m_loaded = 0;
        m_latch  = 0;
        m_last   = model_obs();
        @(posedge clk);
        #1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(3);
        check_output("reset_data_out", data_out, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_bit_idx", bit_idx, 0);
        check_output("reset_frame_cnt", frame_cnt, 0);
        mon_en = 1;
        wait_cycles(2);

        apply_stimulus();

        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            wait_cycles(1);
            budget++;
        end
        check_output("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on latch_in and pclk_in (minimum 2).
REQ-002 Parameter TURBO_PERIOD, default 4, sets the number of latch pulses per turbo half-cycle (minimum 1).
REQ-003 The block SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-004 Port clk  input  1  system clock.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port latch_in  input  1  console latch, asynchronous to clk, active-high.
REQ-007 Port pclk_in  input  1  console shift clock, asynchronous to clk; the shift point is the rising edge.
REQ-008 Port buttons  input  8  pressed=1; bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
REQ-009 Port data_out  output  1  serial button line, active-low (0 = pressed).
REQ-010 Port busy  output  1  high while a snapshot is loaded and not fully shifted out.
REQ-011 Port bit_idx  output  4  index of the bit currently on data_out; 8 means exhausted.
REQ-012 Port frame_cnt  output  8  count of latch rising edges, wrapping modulo 256.

Function
REQ-013 latch_in and pclk_in SHALL each pass through SYNC_STAGES flops, plus one history flop for edge detection.
REQ-014 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-015 IDLE: data_out=1, bit_idx=0, busy=0.
REQ-016 A synchronized latch rising edge in any state SHALL enter LOAD, capture buttons into an 8-bit snapshot, and increment frame_cnt.
REQ-017 In LOAD (latch high), the snapshot SHALL be recaptured every cycle, with data_out = ~snapshot[0], bit_idx=0 and busy=1.
REQ-018 A pclk rising edge while latch is high SHALL be ignored.
REQ-019 A synchronized latch falling edge SHALL move LOAD to SHIFT; the snapshot then freezes and later buttons changes have no effect until the next latch.
REQ-020 In SHIFT, each synchronized pclk rising edge SHALL increment bit_idx and set data_out = ~snapshot[bit_idx].
REQ-021 When bit_idx reaches 8, the FSM SHALL enter DONE.
REQ-022 DONE: data_out=1 (released/open-bus), bit_idx holds at 8, busy=0, and further pclk edges are ignored.
REQ-023 data_out SHALL be registered and SHALL change no later than SYNC_STAGES+2 clk cycles after the causing external edge.
REQ-024 Simultaneous synchronized latch rise and pclk rise: latch wins, giving LOAD with bit_idx=0.
REQ-025 A latch rise in SHIFT or DONE SHALL abort the shift and reload per REQ-016.
REQ-026 bit_idx SHALL never exceed 8 and SHALL never wrap.

Reset
REQ-027 While rst is high: state=IDLE, data_out=1, busy=0, bit_idx=0, frame_cnt=0, snapshot=0, all synchronizer and history flops=0, turbo counter and phase=0.
REQ-028 Reset asserted mid-shift SHALL take effect on the next clk edge.
REQ-029 After reset, a latch already high SHALL count as a rising edge and enter LOAD.

Configuration
REQ-030 Macro NES_PAD_TURBO_EN.
REQ-031 With NES_PAD_TURBO_EN defined: a latch-edge counter toggles turbo_phase every TURBO_PERIOD latch rises; snapshot bits 0 and 1 are captured as buttons[n] AND turbo_phase; bits 2-7 are unaffected.
REQ-032 With NES_PAD_TURBO_EN undefined: the turbo counter is absent and the snapshot equals buttons exactly.

Verification
REQ-033 Reset, then idle: data_out=1, busy=0, bit_idx=0, frame_cnt=0.
REQ-034 buttons=8'b0000_0101, latch pulse, 8 pclk pulses (each edge spaced ≥8 clk) -> data_out sequence 0,1,0,1,1,1,1,1, then 1 in DONE, busy=0, frame_cnt=1.
REQ-035 buttons changed to 8'hFF after latch falls, then shift -> original snapshot shifted out unchanged.
REQ-036 Latch rise after 3 pclk pulses -> bit_idx=0, data_out=~buttons[0], frame_cnt incremented.
REQ-037 12 pclk pulses after latch -> bit_idx saturates at 8, data_out=1; reset asserted at bit 4 -> IDLE, data_out=1 next cycle.
REQ-038 With NES_PAD_TURBO_EN, TURBO_PERIOD=4, A held for 16 frames -> bit0 reads pressed/released alternating in runs of 4 frames; without the macro -> pressed in all 16 frames.
